// File: rtl/jt49_echo_if.sv
// rtl/jt49_echo_if.sv - sample/control bundle between the PSG mixer side and the echo stage
interface jt49_echo_if #(
  parameter int dw    = 16,
  parameter int depth = 10,
  parameter int gw    = 4
);
  logic                    cen;
  logic signed [dw-1:0]    din;
  logic        [depth-1:0] dly;
  logic        [gw-1:0]    fb;
  logic        [gw-1:0]    mix;
  logic signed [dw-1:0]    dout;
  logic                    dvalid;
  logic                    busy;
  logic                    ovr;

  modport master (output cen, din, dly, fb, mix, input dout, dvalid, busy, ovr);
  modport slave  (input cen, din, dly, fb, mix, output dout, dvalid, busy, ovr);
endinterface

// File: rtl/jt49_echo.sv
// rtl/jt49_echo.sv - feedback comb echo over a RAM delay line, cleared after reset
module jt49_echo #(
  parameter int dw    = 16,
  parameter int depth = 10,
  parameter int gw    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  jt49_echo_if.slave   bus
);
  localparam int pw = dw + gw + 1;

  localparam logic [2:0] S_CLR  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RDW  = 3'd3;
  localparam logic [2:0] S_CALC = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;

  logic [2:0]              r_state;
  logic [depth-1:0]        r_clr_addr;
  logic [depth-1:0]        r_wrpos;
  logic [depth-1:0]        r_rdaddr;
  logic signed [dw-1:0]    r_din;
  logic [depth-1:0]        r_dly;
  logic [gw-1:0]           r_fb;
  logic [gw-1:0]           r_mix;
  logic signed [dw-1:0]    r_echo;
  logic signed [dw-1:0]    r_wdat;
  logic signed [dw-1:0]    r_onum;
  logic signed [dw-1:0]    r_dout;
  logic                    r_dvalid;
  logic                    r_ovr;
  logic signed [dw-1:0]    r_ram [0:(2**depth)-1];

  logic                    w_we;
  logic [depth-1:0]        w_waddr;
  logic signed [dw-1:0]    w_wdata;
  logic signed [pw-1:0]    w_echo_x;
  logic signed [pw-1:0]    w_din_x;
  logic signed [pw-1:0]    w_fb_x;
  logic signed [pw-1:0]    w_mix_x;
  logic signed [pw-1:0]    w_fbp;
  logic signed [pw-1:0]    w_wetp;
  logic signed [pw-1:0]    w_fbt;
  logic signed [pw-1:0]    w_wet;
  logic signed [pw-1:0]    w_fsum;
  logic signed [pw-1:0]    w_wsum;

  // Clamp when the bits above the dw-bit sign position disagree with the sign.
  function automatic logic signed [dw-1:0] f_sat(input logic signed [pw-1:0] v);
    if (v[pw-1:dw-1] == {(gw+2){v[pw-1]}})
      return v[dw-1:0];
    else if (v[pw-1])
      return {1'b1, {(dw-1){1'b0}}};
    else
      return {1'b0, {(dw-1){1'b1}}};
  endfunction

  assign w_echo_x = {{(gw+1){r_echo[dw-1]}}, r_echo};
  assign w_din_x  = {{(gw+1){r_din[dw-1]}}, r_din};
  assign w_fb_x   = {{(dw+1){1'b0}}, r_fb};
  assign w_mix_x  = {{(dw+1){1'b0}}, r_mix};
  assign w_fbp    = w_echo_x * w_fb_x;
  assign w_wetp   = w_echo_x * w_mix_x;
  assign w_fbt    = w_fbp  >>> gw;
  assign w_wet    = w_wetp >>> gw;
  assign w_fsum   = w_din_x + w_fbt;
  assign w_wsum   = w_din_x + w_wet;

  // The single write port is shared by the clear sweep and the sample write-back.
  assign w_we    = (r_state == S_CLR) || (r_state == S_WR);
  assign w_waddr = (r_state == S_CLR) ? r_clr_addr : r_wrpos;
  assign w_wdata = (r_state == S_CLR) ? '0 : r_wdat;

  always_ff @(posedge clk) begin
    if (w_we)
      r_ram[w_waddr] <= w_wdata;
    if (r_state == S_RDW)
      r_echo <= r_ram[r_rdaddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLR;
      r_clr_addr <= '0;
      r_wrpos    <= '0;
      r_rdaddr   <= '0;
      r_din      <= '0;
      r_dly      <= '0;
      r_fb       <= '0;
      r_mix      <= '0;
      r_wdat     <= '0;
      r_onum     <= '0;
      r_dout     <= '0;
      r_dvalid   <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      if (bus.cen && (r_state != S_IDLE) && (r_state != S_CLR))
        r_ovr <= 1'b1;
      case (r_state)
        S_CLR: begin
          r_clr_addr <= r_clr_addr + depth'(1);
          if (r_clr_addr == {depth{1'b1}})
            r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (bus.cen) begin
            r_din   <= bus.din;
            r_dly   <= bus.dly;
            r_fb    <= bus.fb;
            r_mix   <= bus.mix;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_rdaddr <= r_wrpos - r_dly;
          r_state  <= S_RDW;
        end
        S_RDW:  r_state <= S_CALC;
        S_CALC: begin
          r_wdat  <= f_sat(w_fsum);
          r_onum  <= f_sat(w_wsum);
          r_state <= S_WR;
        end
        S_WR: begin
          r_wrpos  <= r_wrpos + depth'(1);
          r_dout   <= r_onum;
          r_dvalid <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_CLR;
      endcase
    end
  end

  assign bus.dout   = r_dout;
  assign bus.dvalid = r_dvalid;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.ovr    = r_ovr;
endmodule

// File: tb/tb_jt49_echo.sv
// tb/tb_jt49_echo.sv - scoreboard bench for jt49_echo (depth 10 main instance, depth 4 wrap instance)
module tb_jt49_echo;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   q10[$];
  int   q4[$];
  int   m_ram[1024];
  int   m_wr;

  jt49_echo_if #(.dw(16), .depth(10), .gw(4)) b10();
  jt49_echo_if #(.dw(16), .depth(4),  .gw(4)) b4();

  jt49_echo #(.dw(16), .depth(10), .gw(4)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(b10));
  jt49_echo #(.dw(16), .depth(4),  .gw(4)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference delay line for the depth-10 instance.
  task automatic model10(input int din, input int dly, input int fb, input int mix, output int o);
    int echo;
    echo = m_ram[(m_wr - dly) & 1023];
    m_ram[m_wr] = sat16(din + ((echo * fb) >>> 4));
    m_wr = (m_wr + 1) & 1023;
    o = sat16(din + ((echo * mix) >>> 4));
  endtask

  always @(negedge clk) begin
    if (b10.dvalid) begin
      if (q10.size() == 0) chk("unexpected_dvalid10", 1, 0);
      else chk("dout10", int'(b10.dout), q10.pop_front());
    end
    if (b4.dvalid) begin
      if (q4.size() == 0) chk("unexpected_dvalid4", 1, 0);
      else chk("dout4", int'(b4.dout), q4.pop_front());
    end
  end

  task automatic do_reset();
    int cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_dout", int'(b10.dout), 0);
    chk("rst_dvalid", int'(b10.dvalid), 0);
    chk("rst_busy", int'(b10.busy), 1);
    chk("rst_ovr", int'(b10.ovr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) m_ram[i] = 0;
    m_wr = 0;
    cnt = 0;
    while (b10.busy && cnt < 3000) begin
      b10.cen = (cnt == 100);
      b10.din = 16'sd777;
      @(posedge clk);
      #1;
      cnt++;
    end
    b10.cen = 1'b0;
    chk("clr_cycles", cnt, 1024);
    chk("clr_ovr", int'(b10.ovr), 0);
    chk("clr_busy4", int'(b4.busy), 0);
  endtask

  task automatic send10(input int din, input int dly, input int fb, input int mix);
    int exp;
    int lat;
    model10(din, dly, fb, mix, exp);
    q10.push_back(exp);
    @(negedge clk);
    b10.din = 16'(din);
    b10.dly = 10'(dly);
    b10.fb  = 4'(fb);
    b10.mix = 4'(mix);
    b10.cen = 1'b1;
    @(posedge clk);
    #1;
    b10.cen = 1'b0;
    b10.fb  = 4'($urandom);
    b10.mix = 4'($urandom);
    b10.dly = 10'($urandom);
    lat = 0;
    while (!b10.dvalid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
  endtask

  task automatic send4(input int n);
    int wet;
    wet = (n > 16) ? (((n - 16) * 15) >>> 4) : 0;
    q4.push_back(sat16(n + wet));
    @(negedge clk);
    b4.din = 16'(n);
    b4.cen = 1'b1;
    @(posedge clk);
    #1;
    b4.cen = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    int exp_a;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    b10.cen = 1'b0; b10.din = '0; b10.dly = '0; b10.fb = '0; b10.mix = '0;
    b4.cen  = 1'b0; b4.din  = '0; b4.dly  = '0; b4.fb  = '0; b4.mix  = 4'd15;
    m_wr = 0;

    do_reset();

    // Pure delay: 16000, 0, 0, 15000, 0 ...
    send10(16000, 3, 0, 15);
    for (int i = 0; i < 5; i++) send10(0, 3, 0, 15);

    // Feedback decay and floor rounding of a negative residue
    do_reset();
    send10(1024, 1, 8, 0);
    for (int i = 0; i < 5; i++) send10(0, 1, 8, 0);
    for (int i = 0; i < 2; i++) send10(0, 1, 8, 15);
    send10(-1, 1, 8, 0);
    for (int i = 0; i < 3; i++) send10(0, 1, 8, 0);
    for (int i = 0; i < 2; i++) send10(0, 1, 8, 15);

    // Saturation both ways
    do_reset();
    send10(32767, 1, 15, 0);
    send10(32767, 1, 15, 0);
    send10(0, 1, 15, 15);
    do_reset();
    send10(-32768, 1, 15, 15);
    send10(-32768, 1, 15, 15);
    send10(0, 1, 0, 15);

    // Wrap with dly=0 on the 16-word instance
    b4.dly = '0; b4.fb = '0; b4.mix = 4'd15;
    for (int n = 1; n <= 40; n++) send4(n);

    // Overrun: second cen two clocks after the first is dropped
    chk("ovr_before", int'(b10.ovr), 0);
    model10(5000, 2, 4, 8, exp_a);
    q10.push_back(exp_a);
    @(negedge clk);
    b10.din = 16'sd5000; b10.dly = 10'd2; b10.fb = 4'd4; b10.mix = 4'd8;
    b10.cen = 1'b1;
    @(posedge clk); #1;
    b10.cen = 1'b0;
    @(posedge clk); #1;
    b10.cen = 1'b1;
    b10.din = 16'sd9999;
    @(posedge clk); #1;
    b10.cen = 1'b0;
    chk("ovr_set", int'(b10.ovr), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("ovr_sticky", int'(b10.ovr), 1);
    chk("dout_before_rst", int'(b10.dout), exp_a);

    // Reset while a sample sits in RDW: it must vanish
    @(negedge clk);
    b10.din = 16'sd1234; b10.cen = 1'b1;
    @(posedge clk); #1;
    b10.cen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", int'(b10.dout), 0);
    chk("midrst_ovr", int'(b10.ovr), 0);
    chk("midrst_busy", int'(b10.busy), 1);
    do_reset();
    send10(321, 5, 0, 15);

    repeat (10) @(posedge clk);
    chk("q10_empty", q10.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
